// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, default bit timing
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int CLKS_PER_BIT_DEF = 16;
    // Wide enough for the largest legal CLKS_PER_BIT (65535).
    localparam int CNT_W            = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity is the XOR of the byte; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle: byte/request/flow-control in, line/status out.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              cts_n;
    logic              tx;
    logic              tx_busy;
    logic              tx_done;

    // master: whoever feeds bytes in; slave: the transmitter itself.
    modport master (output tx_data, tx_start, cts_n, input tx, tx_busy, tx_done);
    modport slave  (input tx_data, tx_start, cts_n, output tx, tx_busy, tx_done);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-cycle counter: ticks once every CLKS_PER_BIT cycles, on the last cycle
// of a bit. restart holds it at the top of a bit so the next bit is full length.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count down to zero, reloading at every bit boundary or on restart.
    // NOTE: default assignment first, so no path leaves cnt_d unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one
// stop bit. The line is driven straight from a flop so it never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
)(
    input logic      clk,
    input logic      rst_n,
    uart_tx_if.slave bus
);

    localparam int              IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;

    // Held in restart while idle, so the start bit always gets a full bit time.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    // Next-state and next-output logic; each transition also sets the line
    // value for the coming bit, so tx changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_start && !bus.cts_n) begin
                    state_d   = START;
                    shift_d   = bus.tx_data;
                    parity_d  = parity_bit(bus.tx_data, PARITY_ODD);
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame with the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity, even parity, odd parity),
// a line monitor per instance that rebuilds each frame and compares it with
// the frame the tests queued when they issued the request.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int C   = 4;
    localparam int NB0 = 10;
    localparam int NBP = 11;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    int done_cnt  [3] = '{0, 0, 0};
    int done_cyc  [3] = '{0, 0, 0};
    int start_cyc [3] = '{0, 0, 0};

    // Expected frames, bit 0 = first bit on the line.
    logic [10:0] exp_q0 [$];
    logic [10:0] exp_q1 [$];
    logic [10:0] exp_q2 [$];

    uart_tx_if if0 ();
    uart_tx_if if_e ();
    uart_tx_if if_o ();

    uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
        dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e));
    uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
        dut_o (.clk(clk), .rst_n(rst_n), .bus(if_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic line_tx(input int sel);
        case (sel)
            0:       return if0.tx;
            1:       return if_e.tx;
            default: return if_o.tx;
        endcase
    endfunction

    function automatic logic line_busy(input int sel);
        case (sel)
            0:       return if0.tx_busy;
            1:       return if_e.tx_busy;
            default: return if_o.tx_busy;
        endcase
    endfunction

    function automatic logic line_done(input int sel);
        case (sel)
            0:       return if0.tx_done;
            1:       return if_e.tx_done;
            default: return if_o.tx_done;
        endcase
    endfunction

    task automatic drive(input int sel, input logic [7:0] data, input logic start, input logic cts);
        case (sel)
            0:       begin if0.tx_data  = data; if0.tx_start  = start; if0.cts_n  = cts; end
            1:       begin if_e.tx_data = data; if_e.tx_start = start; if_e.cts_n = cts; end
            default: begin if_o.tx_data = data; if_o.tx_start = start; if_o.cts_n = cts; end
        endcase
    endtask

    task automatic push(input int sel, input logic [10:0] f);
        case (sel)
            0:       exp_q0.push_back(f);
            1:       exp_q1.push_back(f);
            default: exp_q2.push_back(f);
        endcase
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pop(input int sel, output logic [10:0] f);
        case (sel)
            0:       f = exp_q0.pop_front();
            1:       f = exp_q1.pop_front();
            default: f = exp_q2.pop_front();
        endcase
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input bit pe, input bit odd);
        logic [10:0] f;
        f    = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = d[i];
        if (pe) begin
            f[9]  = (^d) ^ odd;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    // Watches one line on falling clk edges: every bit must hold C cycles,
    // busy must stay high through the frame, done must pulse right after it.
    task automatic monitor(input int sel);
        logic        prev = 1'b1;
        logic [10:0] got;
        logic [10:0] want;
        bit          held_ok;
        bit          timing_ok;
        bit          abort;
        int          nb = (sel == 0) ? NB0 : NBP;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev === 1'b1 && line_tx(sel) === 1'b0) begin
                start_cyc[sel] = cyc;
                got       = '0;
                held_ok   = 1'b1;
                timing_ok = 1'b1;
                abort     = 1'b0;
                for (int n = 0; n <= nb * C && !abort; n++) begin
                    if (n > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                    end else if (n < nb * C) begin
                        if (n % C == 0) got[n / C] = line_tx(sel);
                        else if (line_tx(sel) !== got[n / C]) held_ok = 1'b0;
                        if (line_busy(sel) !== 1'b1 || line_done(sel) !== 1'b0) timing_ok = 1'b0;
                    end else if (line_tx(sel) !== 1'b1 || line_busy(sel) !== 1'b0 ||
                                 line_done(sel) !== 1'b1) begin
                        timing_ok = 1'b0;
                    end
                end
                if (!abort) begin
                    done_cyc[sel] = cyc;
                    done_cnt[sel]++;
                    checks++;
                    if (qsize(sel) == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected[%0d]: got frame %b, required no frame", sel, got);
                    end else begin
                        pop(sel, want);
                        if (got !== want || !held_ok) begin
                            errors++;
                            $display("FAIL frame_bits[%0d]: got %b (bits held=%0d), required %b (held=1)",
                                     sel, got, held_ok, want);
                        end
                    end
                    checks++;
                    if (!timing_ok) begin
                        errors++;
                        $display("FAIL frame_handshake[%0d]: busy/done/stop timing wrong, required busy high then one done pulse", sel);
                    end
                end
            end
            prev = line_tx(sel);
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic wait_done(input int sel, input int target, input string tag);
        int n = 0;
        while (done_cnt[sel] < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt[sel] < target) begin
            errors++;
            $display("FAIL %s_timeout: got %0d tx_done pulses, required %0d", tag, done_cnt[sel], target);
        end
    endtask

    task automatic accept_frame(input int sel, input logic [7:0] data, output int acc);
        @(negedge clk);
        drive(sel, data, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        acc = cyc;
        drive(sel, data, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (line_tx(s) !== 1'b1 || line_busy(s) !== 1'b0 || line_done(s) !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got tx=%b busy=%b done=%b, required 1 0 0",
                         s, line_tx(s), line_busy(s), line_done(s));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (line_tx(s) !== 1'b1 || line_busy(s) !== 1'b0 || line_done(s) !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: got tx=%b busy=%b done=%b, required 1 0 0",
                         s, line_tx(s), line_busy(s), line_done(s));
            end
        end
    endtask

    task automatic test_basic();
        int acc;
        int base = done_cnt[0];
        accept_frame(0, 8'hA5, acc);
        // 0,1,0,1,0,0,1,0,1,1 on the line
        push(0, 11'h34A);
        wait_done(0, base + 1, "basic");
        checks++;
        if (start_cyc[0] !== acc) begin
            errors++;
            $display("FAIL basic_start_latency: start bit seen at cycle %0d, required %0d", start_cyc[0], acc);
        end
        checks++;
        if (done_cyc[0] - acc !== 40) begin
            errors++;
            $display("FAIL basic_frame_len: got %0d cycles, required 40", done_cyc[0] - acc);
        end
    endtask

    task automatic test_parity();
        int acc;
        int b1 = done_cnt[1];
        int b2 = done_cnt[2];
        @(negedge clk);
        drive(1, 8'h07, 1'b1, 1'b0);
        drive(2, 8'h07, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        acc = cyc;
        drive(1, 8'h07, 1'b0, 1'b0);
        drive(2, 8'h07, 1'b0, 1'b0);
        push(1, 11'h60E);  // even: parity bit 1
        push(2, 11'h40E);  // odd: parity bit 0
        wait_done(1, b1 + 1, "parity_even");
        wait_done(2, b2 + 1, "parity_odd");
        for (int s = 1; s < 3; s++) begin
            checks++;
            if (done_cyc[s] - acc !== 44) begin
                errors++;
                $display("FAIL parity_frame_len[%0d]: got %0d cycles, required 44", s, done_cyc[s] - acc);
            end
        end
    endtask

    task automatic test_cts_hold();
        int acc;
        bit idle_ok = 1'b1;
        int base = done_cnt[0];
        @(negedge clk);
        drive(0, 8'h5A, 1'b1, 1'b1);
        repeat (20) begin
            @(negedge clk);
            if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL cts_hold: line left idle while cts_n=1, required tx=1 busy=0 throughout");
        end
        drive(0, 8'h5A, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        acc = cyc;
        drive(0, 8'h5A, 1'b0, 1'b0);
        push(0, model_frame(8'h5A, 1'b0, 1'b0));
        checks++;
        if (if0.tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL cts_accept_busy: got busy=%b, required 1", if0.tx_busy);
        end
        // cts_n rises mid-frame: the frame must run to completion unchanged
        repeat (10) @(posedge clk);
        #1;
        drive(0, 8'h5A, 1'b0, 1'b1);
        wait_done(0, base + 1, "cts");
        drive(0, 8'h5A, 1'b0, 1'b0);
        checks++;
        if (start_cyc[0] !== acc) begin
            errors++;
            $display("FAIL cts_start_latency: start bit seen at cycle %0d, required %0d", start_cyc[0], acc);
        end
        checks++;
        if (done_cyc[0] - acc !== 40) begin
            errors++;
            $display("FAIL cts_frame_len: got %0d cycles, required 40", done_cyc[0] - acc);
        end
    endtask

    task automatic test_midframe_start();
        int acc;
        int base = done_cnt[0];
        accept_frame(0, 8'hA5, acc);
        push(0, 11'h34A);
        repeat (12) @(negedge clk);
        drive(0, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 8'h3C, 1'b0, 1'b0);
        wait_done(0, base + 1, "midframe");
        checks++;
        if (done_cyc[0] - acc !== 40) begin
            errors++;
            $display("FAIL midframe_frame_len: got %0d cycles, required 40", done_cyc[0] - acc);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_no_queue: got tx=%b busy=%b, required idle 1 0", if0.tx, if0.tx_busy);
        end
    endtask

    task automatic test_reset_midframe();
        int  acc;
        bit  no_done = 1'b1;
        int  base = done_cnt[0];
        accept_frame(0, 8'h00, acc);
        repeat (15) @(posedge clk);
        #2;
        checks++;
        if (if0.tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_preline: got tx=%b in data bit 2 of 0x00, required 0", if0.tx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got tx=%b busy=%b done=%b, required 1 0 0",
                     if0.tx, if0.tx_busy, if0.tx_done);
        end
        repeat (3) begin
            @(negedge clk);
            if (if0.tx_done !== 1'b0) no_done = 1'b0;
        end
        checks++;
        if (!no_done || done_cnt[0] !== base) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d extra done pulses, required 0", done_cnt[0] - base);
        end
        rst_n = 1'b1;
        drive(0, 8'h55, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        acc = cyc;
        drive(0, 8'h55, 1'b0, 1'b0);
        push(0, model_frame(8'h55, 1'b0, 1'b0));
        wait_done(0, base + 1, "reset_new_frame");
        checks++;
        if (done_cyc[0] - acc !== 40 || done_cnt[0] !== base + 1) begin
            errors++;
            $display("FAIL reset_new_frame: got len=%0d pulses=%0d, required len=40 pulses=1",
                     done_cyc[0] - acc, done_cnt[0] - base);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        int d1;
        int base = done_cnt[0];
        @(negedge clk);
        drive(0, 8'h81, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        acc1 = cyc;
        push(0, model_frame(8'h81, 1'b0, 1'b0));
        push(0, model_frame(8'h81, 1'b0, 1'b0));
        wait_done(0, base + 1, "b2b_first");
        d1 = done_cyc[0];
        checks++;
        if (d1 - acc1 !== 40) begin
            errors++;
            $display("FAIL b2b_first_len: got %0d cycles, required 40", d1 - acc1);
        end
        // The edge closing the tx_done cycle accepts the second frame.
        while (cyc < d1 + 1) begin
            @(posedge clk);
            #1;
        end
        drive(0, 8'h81, 1'b0, 1'b0);
        wait_done(0, base + 2, "b2b_second");
        checks++;
        if (start_cyc[0] !== d1 + 1) begin
            errors++;
            $display("FAIL b2b_gap: second start bit at cycle %0d, required %0d", start_cyc[0], d1 + 1);
        end
        checks++;
        if (done_cyc[0] - (d1 + 1) !== 40) begin
            errors++;
            $display("FAIL b2b_done_spacing: got %0d cycles after the done cycle, required 40",
                     done_cyc[0] - (d1 + 1));
        end
        repeat (8) @(negedge clk);
        checks++;
        if (if0.tx !== 1'b1 || if0.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got tx=%b busy=%b, required idle 1 0", if0.tx, if0.tx_busy);
        end
    endtask

    task automatic test_drain();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (qsize(s) != 0) begin
                errors++;
                $display("FAIL drain[%0d]: got %0d frames never sent, required 0", s, qsize(s));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_parity();
        test_cts_hold();
        test_midframe_start();
        test_reset_midframe();
        test_back_to_back();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
